mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between an instruction-fetch
// requester and a data (load/store) requester. Data normally wins, but a
// waiting fetch is forced through after STARVE_LIMIT back-to-back data
// grants. Each access is bounded by TIMEOUT BUSY cycles, and a timed-out
// access completes with err and zero data.
module mem_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    // instruction-fetch port (read only)
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [31:0]       i_rdata,
    // data port (load / store)
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    // timeout indication, coincident with the ack
    output logic              err,
    // memory side
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    logic [SW-1:0] dStreak;     // consecutive data grants made while a fetch waited
    logic [CW-1:0] waitCnt;     // BUSY cycle number of the current access, from 1
    logic          ownerData;   // 1: current access belongs to the data port
    logic          streakFull;
    logic          grantData;

    // Data wins unless a fetch is waiting and has already been passed over
    // the maximum number of times.
    assign streakFull = (dStreak == SW'(STARVE_LIMIT));
    assign grantData  = d_req && !(i_req && streakFull);

    // Main controller: arbitration, memory access sequencing and response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dStreak   <= '0;
            waitCnt   <= '0;
            ownerData <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_ack     <= 1'b0;
            i_rdata   <= '0;
            d_ack     <= 1'b0;
            d_rdata   <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        state     <= BUSY;
                        mem_en    <= 1'b1;
                        waitCnt   <= CW'(1);
                        ownerData <= grantData;
                        if (grantData) begin
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            // Only grants that pass over a waiting fetch count.
                            if (i_req) begin
                                if (!streakFull) begin
                                    dStreak <= dStreak + 1'b1;
                                end
                            end else begin
                                dStreak <= '0;
                            end
                        end else begin
                            mem_we   <= 1'b0;
                            mem_addr <= i_addr;
                            dStreak  <= '0;
                        end
                    end
                end

                BUSY: begin
                    // A ready in the final allowed cycle still completes normally.
                    if (mem_ready) begin
                        state  <= RESP;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        if (ownerData) begin
                            d_ack   <= 1'b1;
                            d_rdata <= mem_we ? 32'd0 : mem_rdata;
                        end else begin
                            i_ack   <= 1'b1;
                            i_rdata <= mem_rdata;
                        end
                    end else if (waitCnt == CW'(TIMEOUT)) begin
                        state  <= RESP;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        err    <= 1'b1;
                        if (ownerData) begin
                            d_ack   <= 1'b1;
                            d_rdata <= '0;
                        end else begin
                            i_ack   <= 1'b1;
                            i_rdata <= '0;
                        end
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end

                RESP: begin
                    state <= IDLE;
                    i_ack <= 1'b0;
                    d_ack <= 1'b0;
                    err   <= 1'b0;
                end

                default: begin
                    state  <= IDLE;
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    i_ack  <= 1'b0;
                    d_ack  <= 1'b0;
                    err    <= 1'b0;
                end
            endcase
        end
    end

endmodule
